// File: rtl/bcd_counter_display.sv
// Four-digit BCD event counter advanced by a debounced pushbutton, driving a
// time-multiplexed common-anode 7-segment display.
module bcd_counter_display #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REFRESH_CYCLES  = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw,
  input  logic        step,
  input  logic        clr,
  output logic [15:0] digits,
  output logic        carry_out,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RF_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_CYCLES - 1);
  localparam logic [RF_W-1:0] RF_ONE  = RF_W'(1);

  function automatic logic [3:0] next_digit(input logic [3:0] q);
    next_digit = (q == 4'd9) ? 4'd0 : q + 4'd1;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  logic            step_p0, step_s;
  logic            sw_p0, sw_s;
  logic [DB_W-1:0] db_cnt;
  logic            db, db_q;
  logic            tick;
  logic [15:0]     count_q;
  logic [15:0]     count_inc;
  logic            wrap;
  logic            carry_q;
  logic [RF_W-1:0] ref_cnt;
  logic [1:0]      scan_idx, scan_nxt;
  logic [3:0]      sel_digit;
  logic [3:0]      an_q;
  logic [6:0]      seg_q;

  // Stage p0/s: two-flop synchronizers for the asynchronous switch and button
  always_ff @(posedge clk) begin
    if (rst) begin
      step_p0 <= 1'b0;
      step_s  <= 1'b0;
      sw_p0   <= 1'b0;
      sw_s    <= 1'b0;
    end else begin
      step_p0 <= step;
      step_s  <= step_p0;
      sw_p0   <= sw;
      sw_s    <= sw_p0;
    end
  end

  // Debounce: a new level is accepted only after it has held long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      db     <= 1'b0;
      db_q   <= 1'b0;
    end else begin
      db_q <= db;
      if (step_s == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db     <= step_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_ONE;
      end
    end
  end

  assign tick = db & ~db_q;

  // Digit k advances only when every lower digit is 9; wrap marks 9999
  always_comb begin
    logic lower_nine;
    count_inc  = count_q;
    lower_nine = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (lower_nine) count_inc[4*k +: 4] = next_digit(count_q[4*k +: 4]);
      lower_nine = lower_nine & (count_q[4*k +: 4] == 4'd9);
    end
    wrap = lower_nine;
  end

  // Count update: clear beats an increment arriving in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else if (clr) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else if (tick && sw_s) begin
      count_q <= count_inc;
      carry_q <= wrap;
    end else begin
      carry_q <= 1'b0;
    end
  end

  assign scan_nxt = (ref_cnt == RF_LAST) ? scan_idx + 2'd1 : scan_idx;

  always_comb begin
    case (scan_nxt)
      2'd0:    sel_digit = count_q[3:0];
      2'd1:    sel_digit = count_q[7:4];
      2'd2:    sel_digit = count_q[11:8];
      default: sel_digit = count_q[15:12];
    endcase
  end

  // Display scan: anode and segment registers load together so no digit ghosts
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt  <= '0;
      scan_idx <= 2'd0;
      an_q     <= 4'b1110;
      seg_q    <= 7'b1000000;
    end else begin
      ref_cnt  <= (ref_cnt == RF_LAST) ? '0 : ref_cnt + RF_ONE;
      scan_idx <= scan_nxt;
      an_q     <= ~(4'b0001 << scan_nxt);
      seg_q    <= seg_decode(sel_digit);
    end
  end

  assign digits    = count_q;
  assign carry_out = carry_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Bench for bcd_counter_display: scheduled count expectations in a scoreboard
// queue, plus per-scenario inline checks of reset, scan and display decode.
module tb_bcd_counter_display;

  localparam int DB = 4;
  localparam int RF = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sw = 1'b0;
  logic        step = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] digits;
  logic        carry_out;
  logic [3:0]  an;
  logic [6:0]  seg;

  bcd_counter_display #(.DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RF)) dut (
    .clk(clk), .rst(rst), .sw(sw), .step(step), .clr(clr),
    .digits(digits), .carry_out(carry_out), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [15:0] d;
    logic        c;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic [15:0] frc;

  logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Scoreboard consumer: compares each entry on the cycle it was scheduled for
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.at != cyc || digits !== e.d || carry_out !== e.c) begin
        errors++;
        $display("FAIL %s: cycle %0d digits=%h carry=%b, expected cycle %0d digits=%h carry=%b",
                 e.name, cyc, digits, carry_out, e.at, e.d, e.c);
      end
    end
  end

  task automatic expect_at(input int at, input int v, input logic c, input string name);
    exp_t e;
    e.at = at; e.d = to_bcd(v); e.c = c; e.name = name;
    sb.push_back(e);
  endtask

  // Clean press rising at this negedge; count changes 7 edges later if enabled
  task automatic press(input int hold, input bit counts, input string name);
    int n;
    n = cyc;
    step = 1'b1;
    expect_at(n + 6, exp_count, 1'b0, {name, "_before"});
    if (counts) exp_count = (exp_count + 1) % 10000;
    expect_at(n + 7, exp_count, (counts && exp_count == 0), {name, "_after"});
    expect_at(n + 8, exp_count, 1'b0, {name, "_settled"});
    repeat (hold) @(negedge clk);
    step = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic set_count(input int v);
    frc = to_bcd(v);
    force dut.count_q = frc;
    @(negedge clk);
    release dut.count_q;
    exp_count = v;
    @(negedge clk);
  endtask

  task automatic check_digits(input string name);
    checks++;
    if (digits !== to_bcd(exp_count)) begin
      errors++;
      $display("FAIL %s: digits=%h expected %h", name, digits, to_bcd(exp_count));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (digits !== 16'h0000 || carry_out !== 1'b0 || an !== 4'b1110 || seg !== 7'b1000000) begin
      errors++;
      $display("FAIL %s: digits=%h carry=%b an=%b seg=%b expected 0000 0 1110 1000000",
               name, digits, carry_out, an, seg);
    end
  endtask

  task automatic test_display(input string name);
    for (int k = 0; k < 4; k++) begin
      int waited;
      logic [3:0] want_an;
      logic [15:0] bcd;
      logic [3:0] dv;
      waited = 0;
      want_an = ~(4'b0001 << k);
      while (an !== want_an && waited < 16) begin
        @(negedge clk);
        waited++;
      end
      bcd = to_bcd(exp_count);
      dv = bcd[4*k +: 4];
      checks++;
      if (an !== want_an || seg !== glyph[dv]) begin
        errors++;
        $display("FAIL %s_digit%0d: an=%b seg=%b expected an=%b seg=%b",
                 name, k, an, seg, want_an, glyph[dv]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_initial");
  endtask

  task automatic test_scan();
    logic [3:0] want_an;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j <= 24; j++) begin
      if (j > 0) @(negedge clk);
      want_an = ~(4'b0001 << ((j / 3) % 4));
      checks++;
      if (an !== want_an || seg !== 7'b1000000 || carry_out !== 1'b0 || digits !== 16'h0000) begin
        errors++;
        $display("FAIL scan_j%0d: an=%b seg=%b carry=%b digits=%h expected an=%b seg=1000000 carry=0 digits=0000",
                 j, an, seg, carry_out, digits, want_an);
      end
    end
    exp_count = 0;
  endtask

  task automatic test_single_step();
    sw = 1'b1;
    repeat (3) @(negedge clk);
    press(10, 1'b1, "single");
    check_digits("single_no_release_count");
  endtask

  task automatic test_bounce();
    step = 1'b1; @(negedge clk);
    step = 1'b0; @(negedge clk);
    step = 1'b1; @(negedge clk);
    step = 1'b0; @(negedge clk);
    press(10, 1'b1, "bounce");
    check_digits("bounce_single_increment");
  endtask

  task automatic test_cascade();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_count = 0;
    @(negedge clk);
    check_digits("clr_to_zero");
    for (int i = 0; i < 9; i++) press(8, 1'b1, "preload");
    check_digits("preload_0009");
    press(8, 1'b1, "cascade_0010");
    test_display("disp_0010");
  endtask

  task automatic test_wrap();
    set_count(9998);
    press(8, 1'b1, "to_9999");
    test_display("disp_9999");
    press(8, 1'b1, "wrap_0000");
  endtask

  task automatic test_back_to_back();
    set_count(1234);
    press(8, 1'b1, "b2b_a");
    press(8, 1'b1, "b2b_b");
    test_display("disp_1236");
  endtask

  task automatic test_sw_off();
    sw = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) press(8, 1'b0, "sw_off");
    check_digits("sw_off_unchanged");
    sw = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clr_tick();
    int n;
    set_count(42);
    n = cyc;
    step = 1'b1;
    expect_at(n + 6, 42, 1'b0, "clr_tick_before");
    expect_at(n + 7, 0, 1'b0, "clr_tick_after");
    repeat (6) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_count = 0;
    repeat (4) @(negedge clk);
    step = 1'b0;
    repeat (12) @(negedge clk);
    check_digits("clr_tick_lost");
    test_display("disp_after_clr");
  endtask

  task automatic test_reset_mid();
    int n;
    set_count(123);
    n = cyc;
    step = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid_debounce");
    rst = 1'b0;
    exp_count = 0;
    expect_at(n + 11, 0, 1'b0, "post_reset_before");
    expect_at(n + 12, 1, 1'b0, "post_reset_after");
    exp_count = 1;
    repeat (10) @(negedge clk);
    step = 1'b0;
    repeat (12) @(negedge clk);
    check_digits("post_reset_count");
  endtask

  initial begin
    int waited;
    test_reset();
    test_scan();
    test_single_step();
    test_bounce();
    test_cascade();
    test_wrap();
    test_back_to_back();
    test_sw_off();
    test_clr_tick();
    test_reset_mid();
    waited = 0;
    while (sb.size() > 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_counter_display.md
Name: bcd_counter_display

Overview:
- Four-digit decimal event counter with a multiplexed 7-segment output, for the board-level counter demo.
- Holds the BCD digit registers whose per-digit next-value rule is: hold when disabled; Q+1 when enabled and Q≠9; 0 when enabled and Q=9.
- Adds digit cascade, a debounced step pushbutton, a synchronous clear, and a time-multiplexed common-anode display driver.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a new button level (10 ms at 50 MHz); must be ≥2.
- REFRESH_CYCLES, 50000: cycles each digit stays lit before the scan advances; must be ≥2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- sw  input  1  count enable (slide switch), asynchronous to clk.
- step  input  1  raw pushbutton, active-high, bouncy, asynchronous.
- clr  input  1  synchronous clear of the count, active-high, already synchronous to clk.
- digits  output  16  BCD count; [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands.
- carry_out  output  1  one-cycle pulse when the count wraps 9999→0000.
- an  output  4  digit anodes, active-low, one-hot-zero; an[0] is units.
- seg  output  7  segments, active-low; seg[0]=a … seg[6]=g.

Behaviour:
- Reset (rst=1 at a clock edge), effective the next cycle:
  - digits=0, carry_out=0, an=4'b1110, seg=7'b1000000 (glyph "0").
  - Synchronizers, debounced level and debounce counter cleared; refresh counter=0; scan index=0.
  - rst has priority over everything; asserting it mid-count or mid-debounce discards all progress.
- Synchronization:
  - step and sw each pass through a 2-flop synchronizer; internal logic uses only the synchronized versions (step_s, sw_s).
- Debounce:
  - Counter increments every cycle step_s differs from the debounced level db; it clears to 0 whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while they still differ: db takes step_s and the counter clears.
  - A bounce that returns to the old level before then leaves db unchanged.
- Tick:
  - tick=1 for exactly one cycle, in the cycle after db goes 0→1. No tick on 1→0.
  - Holding the button produces exactly one tick.
- Count update, at the edge ending a cycle:
  - Priority: rst > clr > (tick & sw_s) > hold.
  - clr: all digits=0, carry_out=0. A simultaneous tick is lost.
  - tick & sw_s:
    - units use the next-value rule above.
    - Digit k (k≥1) advances by the same rule only when all lower digits equal 9; otherwise it holds.
    - Increment of 9999 gives 0000 and carry_out=1 for that one cycle.
  - tick with sw_s=0: count unchanged, tick discarded (not deferred).
  - carry_out=0 in all other cycles.
- Display scan:
  - Refresh counter counts 0..REFRESH_CYCLES-1 and wraps.
  - On the wrap edge, scan index advances 0→1→2→3→0.
  - an is the active-low one-hot of the scan index, registered.
  - seg is the registered decode of the selected digit and changes on the same edge as an (no ghosting skew).
  - Decode table (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any value >9 gives 1111111 (unreachable; defensive).
  - The scan runs regardless of sw, clr or tick.
  - seg reflects the updated digit value at the next scan selection of that digit, or one cycle after the update if the digit is already selected.
- Latency:
  - Clean step rise to digits change = 2 (sync) + DEBOUNCE_CYCLES + 1 (tick) cycles.

Test Plan (DEBOUNCE_CYCLES=4, REFRESH_CYCLES=3):
- Reset then idle 24 cycles → digits=0000, carry_out never 1; an cycles 1110→1101→1011→0111, changing every 3 cycles; seg=1000000 throughout.
- sw=1, clean step pulse held 10 cycles → digits=0001 exactly 7 cycles after the step rise; no second increment on release.
- step toggling 1,0,1,0 every cycle, then steady 1, with sw=1 → exactly one increment, occurring 7 cycles after the final rise.
- Preload via 9 steps to 0009, one more step → 0010. Preload to 9999 (clr then steps, or force), one step → 0000 with carry_out=1 for exactly one cycle.
- sw=0 with 3 valid steps → digits unchanged. clr asserted in the same cycle as tick at 0042 → digits=0000.
- rst asserted mid-debounce (counter=2) and mid-scan → next cycle all outputs at reset values; a step completing later is counted from 0000.
